arm_instr_encoder: RTL and testbench

- Assembles 32-bit ARM instruction words from field-level encode requests. It is the inverse of the core's instruction decoder.
- Used by the boot loader and the test-injection path to place DP, LDR/STR and B instructions into instruction memory or the fetch stream.
- Accepts one request at a time over a valid/ready handshake. Emits the encoded word, or an error flag, over a second valid/ready handshake.
- DP immediates go through a sequential rotation search.

---
 rtl/arm_instr_encoder.sv | 192 +++++++++++++++++++
 tb/tb_arm_instr_encoder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_instr_encoder.sv
// ARM instruction encoder: assembles DP, LDR/STR and B words from field-level requests.
// DP immediates use a one-candidate-per-cycle rotation search for the smallest legal rotation.
module arm_instr_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_class,
    input  logic [3:0]       req_cond,
    input  logic [3:0]       req_opc,
    input  logic             req_s,
    input  logic             req_imm_sel,
    input  logic [3:0]       req_rd,
    input  logic [3:0]       req_rn,
    input  logic [3:0]       req_rm,
    input  logic [31:0]      req_value,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic             instr_err,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {StIdle, StSearch, StEmit} state_e;

    localparam logic [1:0] ClsDp  = 2'b00;
    localparam logic [1:0] ClsMem = 2'b01;
    localparam logic [1:0] ClsBr  = 2'b10;

    state_e r_state, w_state_next;

    logic [1:0]       r_class;
    logic [3:0]       r_cond;
    logic [3:0]       r_opc;
    logic             r_s;
    logic             r_imm_sel;
    logic [3:0]       r_rd;
    logic [3:0]       r_rn;
    logic [3:0]       r_rm;
    logic [31:0]      r_value;
    logic [3:0]       r_rot;
    logic [11:0]      r_op2;
    logic             r_srch_err;
    logic [CNT_W-1:0] r_count;

    logic [5:0]  w_sh;
    logic [5:0]  w_rsh;
    logic [31:0] w_t;
    logic        w_match;
    logic        w_nowb;
    logic [31:0] w_mag;
    logic        w_mem_err;
    logic        w_br_err;
    logic [31:0] w_word;
    logic        w_err;
    logic        w_start_search;

    assign w_start_search = (req_class == ClsDp) && req_imm_sel;

    // Rotate left by 2*rot; a shift by 32 yields zero, so rot 0 is the value itself.
    assign w_sh    = {1'b0, r_rot, 1'b0};
    assign w_rsh   = 6'd32 - w_sh;
    assign w_t     = (r_value << w_sh) | (r_value >> w_rsh);
    assign w_match = (w_t[31:8] == 24'd0);

    // TST/TEQ/CMP/CMN have no destination and always set flags.
    assign w_nowb    = (r_opc[3:2] == 2'b10);
    assign w_mag     = r_value[31] ? (~r_value + 32'd1) : r_value;
    assign w_mem_err = (w_mag > 32'd4095);
    assign w_br_err  = !((&r_value[31:23]) || (~|r_value[31:23]));

    always_comb begin
        w_word = '0;
        w_err  = 1'b0;
        unique case (r_class)
            ClsDp: begin
                w_err  = r_imm_sel && r_srch_err;
                w_word = {r_cond, 2'b00, r_imm_sel, r_opc, (r_s | w_nowb), r_rn,
                          (w_nowb ? 4'd0 : r_rd),
                          (r_imm_sel ? r_op2 : {8'd0, r_rm})};
            end
            ClsMem: begin
                w_err  = w_mem_err;
                w_word = {r_cond, 2'b01, 1'b0, 1'b1, ~r_value[31], 1'b0, 1'b0, r_s,
                          r_rn, r_rd, w_mag[11:0]};
            end
            ClsBr: begin
                w_err  = w_br_err;
                w_word = {r_cond, 3'b101, 1'b0, r_value[23:0]};
            end
            default: begin
                w_err  = 1'b1;
                w_word = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_state_next = w_start_search ? StSearch : StEmit;
                end
            end
            StSearch: begin
                if (w_match || (r_rot == 4'd15)) begin
                    w_state_next = StEmit;
                end
            end
            StEmit: begin
                if (instr_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req_ready   = (r_state == StIdle);
        busy        = (r_state != StIdle);
        instr_valid = (r_state == StEmit);
        instr_err   = (r_state == StEmit) && w_err;
        instr       = ((r_state == StEmit) && !w_err) ? w_word : 32'd0;
        instr_count = r_count;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_class    <= '0;
            r_cond     <= '0;
            r_opc      <= '0;
            r_s        <= 1'b0;
            r_imm_sel  <= 1'b0;
            r_rd       <= '0;
            r_rn       <= '0;
            r_rm       <= '0;
            r_value    <= '0;
            r_rot      <= '0;
            r_op2      <= '0;
            r_srch_err <= 1'b0;
            r_count    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (req_valid) begin
                        r_class    <= req_class;
                        r_cond     <= req_cond;
                        r_opc      <= req_opc;
                        r_s        <= req_s;
                        r_imm_sel  <= req_imm_sel;
                        r_rd       <= req_rd;
                        r_rn       <= req_rn;
                        r_rm       <= req_rm;
                        r_value    <= req_value;
                        r_rot      <= '0;
                        r_op2      <= '0;
                        r_srch_err <= 1'b0;
                    end
                end
                StSearch: begin
                    if (w_match) begin
                        r_op2 <= {r_rot, w_t[7:0]};
                    end else if (r_rot == 4'd15) begin
                        r_srch_err <= 1'b1;
                    end else begin
                        r_rot <= r_rot + 4'd1;
                    end
                end
                StEmit: begin
                    if (instr_ready && !w_err) begin
                        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Randomized self-checking bench for arm_instr_encoder against a field-level reference model.
module tb_arm_instr_encoder;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_class;
    logic [3:0]  req_cond;
    logic [3:0]  req_opc;
    logic        req_s;
    logic        req_imm_sel;
    logic [3:0]  req_rd;
    logic [3:0]  req_rn;
    logic [3:0]  req_rm;
    logic [31:0] req_value;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_err;
    logic        busy;
    logic [15:0] instr_count;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [15:0] exp_count;

    arm_instr_encoder #(.CNT_W(16)) dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_class   (req_class),
        .req_cond    (req_cond),
        .req_opc     (req_opc),
        .req_s       (req_s),
        .req_imm_sel (req_imm_sel),
        .req_rd      (req_rd),
        .req_rn      (req_rn),
        .req_rm      (req_rm),
        .req_value   (req_value),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_err   (instr_err),
        .busy        (busy),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rol(input logic [31:0] v, input int n);
        logic [31:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = {x[30:0], x[31]};
        return x;
    endfunction

    task automatic model(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] opc,
                         input logic s, input logic imm, input logic [3:0] rd,
                         input logic [3:0] rn, input logic [3:0] rm, input logic [31:0] value,
                         output logic [31:0] e_instr, output logic e_err, output int e_lat);
        longint      sv;
        longint      mag;
        logic [31:0] op2;
        logic [31:0] t;
        bit          found;
        bit          nowb;
        e_instr = 32'd0;
        e_err   = 1'b0;
        e_lat   = 1;
        sv      = longint'($signed(value));
        case (cls)
            2'd0: begin
                nowb = (opc >= 4'd8) && (opc <= 4'd11);
                op2  = 32'(rm);
                if (imm) begin
                    found = 1'b0;
                    for (int r = 0; r < 16; r++) begin
                        t = rol(value, 2 * r);
                        if (!found && t < 32'd256) begin
                            op2   = 32'(r * 256) + t;
                            e_lat = r + 2;
                            found = 1'b1;
                        end
                    end
                    if (!found) begin
                        e_err = 1'b1;
                        e_lat = 17;
                    end
                end
                if (!e_err) begin
                    e_instr = (32'(cond) << 28) | (32'(imm) << 25) | (32'(opc) << 21)
                            | (32'(nowb ? 1'b1 : s) << 20) | (32'(rn) << 16)
                            | (32'(nowb ? 4'd0 : rd) << 12) | op2;
                end
            end
            2'd1: begin
                if (sv > 4095 || sv < -4095) begin
                    e_err = 1'b1;
                end else begin
                    mag     = (sv < 0) ? -sv : sv;
                    e_instr = (32'(cond) << 28) | 32'h0500_0000 | (32'(sv >= 0) << 23)
                            | (32'(s) << 20) | (32'(rn) << 16) | (32'(rd) << 12) | 32'(mag);
                end
            end
            2'd2: begin
                if (sv > 8388607 || sv < -8388608) begin
                    e_err = 1'b1;
                end else begin
                    e_instr = (32'(cond) << 28) | 32'h0A00_0000 | (value & 32'h00FF_FFFF);
                end
            end
            default: e_err = 1'b1;
        endcase
    endtask

    // Entered and left at posedge+1; hold = cycles instr_ready stays low once valid shows.
    task automatic run_req(input logic [1:0] cls, input logic [3:0] cond, input logic [3:0] opc,
                           input logic s, input logic imm, input logic [3:0] rd,
                           input logic [3:0] rn, input logic [3:0] rm, input logic [31:0] value,
                           input int hold, input bit early);
        logic [31:0] e_instr;
        logic        e_err;
        int          e_lat;
        int          lat;
        model(cls, cond, opc, s, imm, rd, rn, rm, value, e_instr, e_err, e_lat);
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_class   = cls;
        req_cond    = cond;
        req_opc     = opc;
        req_s       = s;
        req_imm_sel = imm;
        req_rd      = rd;
        req_rn      = rn;
        req_rm      = rm;
        req_value   = value;
        req_valid   = 1'b1;
        instr_ready = early;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        req_value = $urandom;
        lat = 1;
        while (!instr_valid && lat < 40) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check_eq("instr_valid", 32'(instr_valid), 32'd1);
        if (!instr_valid) return;
        check_eq("latency", 32'(lat), 32'(e_lat));
        check_eq("instr", instr, e_instr);
        check_eq("instr_err", 32'(instr_err), 32'(e_err));
        check_eq("busy_emit", 32'(busy), 32'd1);
        check_eq("req_ready_emit", 32'(req_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge CLK);
            #1;
            check_eq("hold_valid", 32'(instr_valid), 32'd1);
            check_eq("hold_instr", instr, e_instr);
            check_eq("hold_err", 32'(instr_err), 32'(e_err));
            check_eq("hold_count", 32'(instr_count), 32'(exp_count));
        end
        instr_ready = 1'b1;
        @(posedge CLK);
        #1;
        instr_ready = 1'b0;
        if (!e_err) exp_count++;
        check_eq("count", 32'(instr_count), 32'(exp_count));
        check_eq("valid_after", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        logic [1:0]  cls;
        logic [31:0] val;
        int          hold;
        bit          early;
        int          m;

        RESETn      = 1'b0;
        req_valid   = 1'b0;
        req_class   = '0;
        req_cond    = '0;
        req_opc     = '0;
        req_s       = 1'b0;
        req_imm_sel = 1'b0;
        req_rd      = '0;
        req_rn      = '0;
        req_rm      = '0;
        req_value   = '0;
        instr_ready = 1'b0;
        exp_count   = '0;
        #12;
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_err", 32'(instr_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_count", 32'(instr_count), 32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;

        run_req(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 32'h0000_00FF, 0, 1'b0);
        run_req(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 32'h0003_FC00, 1, 1'b0);
        run_req(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 32'h0000_0101, 0, 1'b0);
        run_req(2'd0, 4'hE, 4'b1010, 1'b0, 1'b0, 4'd7, 4'd3, 4'd4, 32'h0000_0000, 0, 1'b0);
        run_req(2'd1, 4'hE, 4'd0, 1'b1, 1'b0, 4'd6, 4'd5, 4'd0, -32'sd8, 0, 1'b0);
        run_req(2'd1, 4'hE, 4'd0, 1'b0, 1'b0, 4'd6, 4'd5, 4'd0, 32'd4096, 0, 1'b0);
        run_req(2'd1, 4'hE, 4'd0, 1'b0, 1'b0, 4'd6, 4'd5, 4'd0, 32'd4095, 3, 1'b0);
        run_req(2'd1, 4'hE, 4'd0, 1'b1, 1'b0, 4'd6, 4'd5, 4'd0, -32'sd4096, 0, 1'b0);
        run_req(2'd2, 4'h0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, -32'sd2, 0, 1'b0);
        run_req(2'd2, 4'h0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0080_0000, 0, 1'b0);
        run_req(2'd3, 4'hE, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 32'h0000_0000, 2, 1'b0);

        // Reset in the middle of a long (failing) search.
        req_class   = 2'd0;
        req_imm_sel = 1'b1;
        req_opc     = 4'b0100;
        req_value   = 32'h0000_0101;
        req_valid   = 1'b1;
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
        repeat (5) begin
            @(posedge CLK);
            #1;
        end
        check_eq("search_busy", 32'(busy), 32'd1);
        RESETn = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(instr_valid), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_count", 32'(instr_count), 32'd0);
        check_eq("midrst_instr", instr, 32'd0);
        exp_count = '0;
        @(negedge CLK);
        RESETn = 1'b1;
        @(posedge CLK);
        #1;
        run_req(2'd0, 4'hE, 4'b0100, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 32'h0000_00FF, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            m   = int'($urandom % 8);
            cls = (m < 4) ? 2'd0 : (m < 6) ? 2'd1 : (m < 7) ? 2'd2 : 2'd3;
            m   = int'($urandom % 3);
            case (cls)
                2'd0: begin
                    if (m == 0) val = rol(32'($urandom % 256), (32 - 2 * int'($urandom % 16)) % 32);
                    else if (m == 1) val = $urandom;
                    else val = 32'($urandom_range(0, 1023));
                end
                2'd1: begin
                    if (m == 0) val = 32'($urandom_range(0, 8200)) - 32'd4100;
                    else if (m == 1) val = (($urandom % 2) != 0) ? 32'd4095 : -32'sd4095;
                    else val = $urandom;
                end
                2'd2: begin
                    if (m == 2) val = $urandom;
                    else val = 32'($urandom_range(0, 32'h0100_0010)) - 32'h0080_0008;
                end
                default: val = $urandom;
            endcase
            hold  = int'($urandom_range(0, 3));
            early = (hold == 0) && (($urandom % 2) != 0);
            run_req(cls, 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), 4'($urandom), 4'($urandom), val, hold, early);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
